// File: rtl/riscv_pkg.sv
// Shared types for the RV32 execute stage: ALU opcodes, forwarding selects, result selects.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SUB  = 3'b001,
    ALU_AND  = 3'b010,
    ALU_OR   = 3'b011,
    ALU_XOR  = 3'b100,
    ALU_SLT  = 3'b101,
    ALU_SLTU = 3'b110,
    ALU_ZERO = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    FWD_RD     = 2'b00,
    FWD_WB     = 2'b01,
    FWD_MEM    = 2'b10,
    FWD_RD_ALT = 2'b11
  } fwd_sel_e;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_e;

  // Only beq is decoded, so a branch is taken exactly when the ALU difference is zero.
  function automatic logic pc_redirect(input logic jump, input logic branch, input logic zero);
    return jump | (branch & zero);
  endfunction

endpackage

// File: rtl/ex_stage_if.sv
// ID/EX inputs, forwarding controls and EX/MEM outputs of the execute stage.
interface ex_stage_if #(
  parameter int unsigned XLEN = riscv_pkg::XLEN
);
  logic [XLEN-1:0] PCE, PCPlus4E, RD1E, RD2E, IMMEXIE, ResultW;
  logic [4:0]      RDE;
  logic            RegWriteE, MemWriteE, JumpE, BranchE, AluSrcE;
  logic [1:0]      ResultSrcE;
  logic [2:0]      AluControlE;
  logic [1:0]      ForwardAE, ForwardBE;
  logic            StallM, FlushM;

  logic            PCSrcE;
  logic [XLEN-1:0] PCTargetE;
  logic [XLEN-1:0] ALUResultM, WriteDataM, PCPlus4M;
  logic [4:0]      RDM;
  logic            RegWriteM, MemWriteM;
  logic [1:0]      ResultSrcM;
  logic            ValidM;

  modport master (
    output PCE, PCPlus4E, RD1E, RD2E, IMMEXIE, ResultW, RDE,
           RegWriteE, MemWriteE, JumpE, BranchE, AluSrcE,
           ResultSrcE, AluControlE, ForwardAE, ForwardBE, StallM, FlushM,
    input  PCSrcE, PCTargetE, ALUResultM, WriteDataM, PCPlus4M, RDM,
           RegWriteM, MemWriteM, ResultSrcM, ValidM
  );

  modport slave (
    input  PCE, PCPlus4E, RD1E, RD2E, IMMEXIE, ResultW, RDE,
           RegWriteE, MemWriteE, JumpE, BranchE, AluSrcE,
           ResultSrcE, AluControlE, ForwardAE, ForwardBE, StallM, FlushM,
    output PCSrcE, PCTargetE, ALUResultM, WriteDataM, PCPlus4M, RDM,
           RegWriteM, MemWriteM, ResultSrcM, ValidM
  );
endinterface

// File: rtl/ex_stage_alu.sv
// Combinational RV32 ALU: add/sub/logic/set-less-than with a zero flag for beq.
module alu
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = riscv_pkg::XLEN
) (
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  input  alu_op_e         op,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  always_comb begin
    result = '0;
    unique case (op)
      ALU_ADD:  result = SrcA + SrcB;
      ALU_SUB:  result = SrcA - SrcB;
      ALU_AND:  result = SrcA & SrcB;
      ALU_OR:   result = SrcA | SrcB;
      ALU_XOR:  result = SrcA ^ SrcB;
      ALU_SLT:  result = {{(XLEN-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
      ALU_SLTU: result = {{(XLEN-1){1'b0}}, (SrcA < SrcB)};
      ALU_ZERO: result = '0;
      default:  result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/ex_stage.sv
// RV32 execute stage: operand forwarding, ALU, beq/jump resolution, target adder, EX/MEM register.
module ex_stage
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = riscv_pkg::XLEN
) (
  input  logic      clk,
  input  logic      reset,
  ex_stage_if.slave bus
);

  typedef struct packed {
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] write_data;
    logic [XLEN-1:0] pc_plus4;
    logic [4:0]      rd;
    logic            reg_write;
    logic            mem_write;
    result_src_e     result_src;
    logic            valid;
  } exmem_t;

  logic [XLEN-1:0] src_a, src_b, write_data_e, alu_result_e;
  logic            zero_e;
  exmem_t          exmem_d, exmem_q, ex_val;

  always_comb begin
    src_a = bus.RD1E;
    unique case (fwd_sel_e'(bus.ForwardAE))
      FWD_WB:  src_a = bus.ResultW;
      FWD_MEM: src_a = exmem_q.alu_result;
      default: src_a = bus.RD1E;
    endcase
  end

  always_comb begin
    write_data_e = bus.RD2E;
    unique case (fwd_sel_e'(bus.ForwardBE))
      FWD_WB:  write_data_e = bus.ResultW;
      FWD_MEM: write_data_e = exmem_q.alu_result;
      default: write_data_e = bus.RD2E;
    endcase
  end

  assign src_b = bus.AluSrcE ? bus.IMMEXIE : write_data_e;

  alu #(.XLEN(XLEN)) u_alu (
    .SrcA   (src_a),
    .SrcB   (src_b),
    .op     (alu_op_e'(bus.AluControlE)),
    .result (alu_result_e),
    .zero   (zero_e)
  );

  assign bus.PCSrcE    = pc_redirect(bus.JumpE, bus.BranchE, zero_e);
  assign bus.PCTargetE = bus.PCE + bus.IMMEXIE;

  always_comb begin
    ex_val            = '0;
    ex_val.alu_result = alu_result_e;
    ex_val.write_data = write_data_e;
    ex_val.pc_plus4   = bus.PCPlus4E;
    ex_val.rd         = bus.RDE;
    ex_val.reg_write  = bus.RegWriteE;
    ex_val.mem_write  = bus.MemWriteE;
    ex_val.result_src = result_src_e'(bus.ResultSrcE);
    ex_val.valid      = 1'b1;
  end

  // Flush is tested first so it wins over a simultaneous stall.
  always_comb begin
    exmem_d = exmem_q;
    if (bus.FlushM) begin
      exmem_d           = ex_val;
      exmem_d.reg_write = 1'b0;
      exmem_d.mem_write = 1'b0;
      exmem_d.valid     = 1'b0;
    end else if (!bus.StallM) begin
      exmem_d = ex_val;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) exmem_q <= '0;
    else        exmem_q <= exmem_d;
  end

  assign bus.ALUResultM = exmem_q.alu_result;
  assign bus.WriteDataM = exmem_q.write_data;
  assign bus.PCPlus4M   = exmem_q.pc_plus4;
  assign bus.RDM        = exmem_q.rd;
  assign bus.RegWriteM  = exmem_q.reg_write;
  assign bus.MemWriteM  = exmem_q.mem_write;
  assign bus.ResultSrcM = exmem_q.result_src;
  assign bus.ValidM     = exmem_q.valid;

endmodule

// File: tb/tb_ex_stage.sv
// Directed vector bench for ex_stage: table of ALU/forwarding/branch cases plus stall, flush and reset sequences.
module tb_ex_stage;
  import riscv_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  ex_stage_if #(.XLEN(32)) bus ();

  ex_stage #(.XLEN(32)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [2:0]  op;
    logic [31:0] rd1, rd2, imm;
    logic        asrc;
    logic [1:0]  fa, fb;
    logic [31:0] resw, pc;
    logic        br, jmp;
    logic [4:0]  rd;
    logic        rw, mw;
    logic [1:0]  rs;
    logic [31:0] e_alu, e_wd;
    logic        e_pcsrc;
    logic [31:0] e_tgt;
  } vec_t;

  vec_t vt[16];

  function automatic vec_t mk(
    input logic [2:0] op, input logic [31:0] rd1, input logic [31:0] rd2, input logic [31:0] imm,
    input logic asrc, input logic [1:0] fa, input logic [1:0] fb, input logic [31:0] resw,
    input logic [31:0] pc, input logic br, input logic jmp, input logic [4:0] rd,
    input logic rw, input logic mw, input logic [1:0] rs,
    input logic [31:0] e_alu, input logic [31:0] e_wd, input logic e_pcsrc, input logic [31:0] e_tgt);
    vec_t v;
    v.op = op; v.rd1 = rd1; v.rd2 = rd2; v.imm = imm; v.asrc = asrc; v.fa = fa; v.fb = fb;
    v.resw = resw; v.pc = pc; v.br = br; v.jmp = jmp; v.rd = rd; v.rw = rw; v.mw = mw; v.rs = rs;
    v.e_alu = e_alu; v.e_wd = e_wd; v.e_pcsrc = e_pcsrc; v.e_tgt = e_tgt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v, input logic stall, input logic flush);
    bus.AluControlE = v.op;   bus.RD1E = v.rd1;     bus.RD2E = v.rd2;
    bus.IMMEXIE     = v.imm;  bus.AluSrcE = v.asrc; bus.ForwardAE = v.fa;
    bus.ForwardBE   = v.fb;   bus.ResultW = v.resw; bus.PCE = v.pc;
    bus.PCPlus4E    = v.pc + 32'd4;
    bus.BranchE     = v.br;   bus.JumpE = v.jmp;    bus.RDE = v.rd;
    bus.RegWriteE   = v.rw;   bus.MemWriteE = v.mw; bus.ResultSrcE = v.rs;
    bus.StallM      = stall;  bus.FlushM = flush;
  endtask

  task automatic drive_random();
    bus.AluControlE = 3'($urandom()); bus.RD1E = $urandom(); bus.RD2E = $urandom();
    bus.IMMEXIE = $urandom(); bus.AluSrcE = 1'($urandom()); bus.ForwardAE = 2'($urandom());
    bus.ForwardBE = 2'($urandom()); bus.ResultW = $urandom(); bus.PCE = $urandom();
    bus.PCPlus4E = $urandom(); bus.BranchE = 1'($urandom()); bus.JumpE = 1'($urandom());
    bus.RDE = 5'($urandom()); bus.RegWriteE = 1'b1; bus.MemWriteE = 1'b1;
    bus.ResultSrcE = 2'($urandom()); bus.StallM = 1'($urandom()); bus.FlushM = 1'($urandom());
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_alum"}, bus.ALUResultM, 32'h0);
    chk({tag, "_wdm"},  bus.WriteDataM, 32'h0);
    chk({tag, "_pc4m"}, bus.PCPlus4M,   32'h0);
    chk({tag, "_rdm"},  32'(bus.RDM),        32'h0);
    chk({tag, "_rwm"},  32'(bus.RegWriteM),  32'h0);
    chk({tag, "_mwm"},  32'(bus.MemWriteM),  32'h0);
    chk({tag, "_rsm"},  32'(bus.ResultSrcM), 32'h0);
    chk({tag, "_vm"},   32'(bus.ValidM),     32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t s;
    checks = 0;
    errors = 0;
    //        op       rd1           rd2         imm          as fa    fb    resw     pc           br jp rd  rw mw rs     e_alu        e_wd      pcs tgt
    vt[0]  = mk(ALU_ADD,  32'd5,        32'd7,      32'd0,       0, 2'd0, 2'd0, 32'd0,   32'h0,       0, 0, 3,  1, 0, 2'd0, 32'd12,      32'd7,    0, 32'h0);
    vt[1]  = mk(ALU_ADD,  32'd20,       32'd0,      32'd0,       0, 2'd0, 2'd0, 32'd0,   32'h4,       0, 0, 4,  1, 0, 2'd0, 32'd20,      32'd0,    0, 32'h4);
    vt[2]  = mk(ALU_SUB,  32'd0,        32'd0,      32'd0,       0, 2'd2, 2'd1, 32'd8,   32'h8,       0, 0, 5,  1, 0, 2'd0, 32'd12,      32'd8,    0, 32'h8);
    vt[3]  = mk(ALU_SLT,  32'hFFFFFFFF, 32'd1,      32'd0,       0, 2'd0, 2'd0, 32'd0,   32'hC,       0, 0, 6,  1, 0, 2'd0, 32'd1,       32'd1,    0, 32'hC);
    vt[4]  = mk(ALU_SLTU, 32'hFFFFFFFF, 32'd1,      32'd0,       0, 2'd0, 2'd0, 32'd0,   32'h10,      0, 0, 7,  1, 0, 2'd0, 32'd0,       32'd1,    0, 32'h10);
    vt[5]  = mk(ALU_AND,  32'hF0F0,     32'hFF00,   32'h20,      0, 2'd0, 2'd0, 32'd0,   32'h1000,    0, 0, 8,  1, 0, 2'd0, 32'hF000,    32'hFF00, 0, 32'h1020);
    vt[6]  = mk(ALU_OR,   32'hF0F0,     32'h0F00,   32'd0,       0, 2'd0, 2'd0, 32'd0,   32'h14,      0, 0, 9,  0, 1, 2'd1, 32'hFFF0,    32'h0F00, 0, 32'h14);
    vt[7]  = mk(ALU_XOR,  32'hFF,       32'h0F,     32'd0,       0, 2'd0, 2'd0, 32'd0,   32'h18,      0, 0, 10, 1, 0, 2'd2, 32'hF0,      32'h0F,   0, 32'h18);
    vt[8]  = mk(ALU_ZERO, 32'd5,        32'd0,      32'd0,       0, 2'd0, 2'd0, 32'd0,   32'h1C,      0, 0, 11, 1, 0, 2'd0, 32'd0,       32'd0,    0, 32'h1C);
    vt[9]  = mk(ALU_ADD,  32'd100,      32'h33,     32'hFFFFFFF8,1, 2'd0, 2'd0, 32'd0,   32'h0,       0, 0, 12, 1, 0, 2'd0, 32'd92,      32'h33,   0, 32'hFFFFFFF8);
    vt[10] = mk(ALU_SUB,  32'd9,        32'd9,      32'hFFFFFFF8,0, 2'd0, 2'd0, 32'd0,   32'h100,     1, 0, 0,  0, 0, 2'd0, 32'd0,       32'd9,    1, 32'hF8);
    vt[11] = mk(ALU_SUB,  32'd9,        32'd8,      32'hFFFFFFF8,0, 2'd0, 2'd0, 32'd0,   32'h100,     1, 0, 0,  0, 0, 2'd0, 32'd1,       32'd8,    0, 32'hF8);
    vt[12] = mk(ALU_SUB,  32'd9,        32'd8,      32'hFFFFFFF8,0, 2'd0, 2'd0, 32'd0,   32'h100,     0, 1, 1,  1, 0, 2'd2, 32'd1,       32'd8,    1, 32'hF8);
    vt[13] = mk(ALU_ADD,  32'hFFFFFFFF, 32'd1,      32'd8,       0, 2'd0, 2'd0, 32'd0,   32'hFFFFFFFC,0, 0, 13, 1, 0, 2'd0, 32'd0,       32'd1,    0, 32'h4);
    vt[14] = mk(ALU_ADD,  32'd3,        32'd4,      32'd0,       0, 2'd3, 2'd3, 32'd100, 32'h20,      0, 0, 14, 1, 0, 2'd0, 32'd7,       32'd4,    0, 32'h20);
    vt[15] = mk(ALU_ADD,  32'd0,        32'd0,      32'd0,       0, 2'd1, 2'd2, 32'h40,  32'h24,      0, 0, 15, 1, 0, 2'd0, 32'h47,      32'd7,    0, 32'h24);

    // Reset held across several edges with random inputs.
    rst_n = 1'b0;
    drive_random();
    #1 chk_cleared("rst0");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk_cleared($sformatf("rst%0d", i + 1));
      drive_random();
    end
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    drive(vt[0], 1'b0, 1'b0);

    for (int i = 0; i < 16; i++) begin
      drive(vt[i], 1'b0, 1'b0);
      #1;
      chk($sformatf("v%0d_pcsrc", i), 32'(bus.PCSrcE), 32'(vt[i].e_pcsrc));
      chk($sformatf("v%0d_tgt", i), bus.PCTargetE, vt[i].e_tgt);
      @(posedge clk); #1;
      chk($sformatf("v%0d_alum", i), bus.ALUResultM, vt[i].e_alu);
      chk($sformatf("v%0d_wdm", i), bus.WriteDataM, vt[i].e_wd);
      chk($sformatf("v%0d_pc4m", i), bus.PCPlus4M, vt[i].pc + 32'd4);
      chk($sformatf("v%0d_rdm", i), 32'(bus.RDM), 32'(vt[i].rd));
      chk($sformatf("v%0d_ctl", i), {28'h0, bus.RegWriteM, bus.MemWriteM, bus.ResultSrcM},
          {28'h0, vt[i].rw, vt[i].mw, vt[i].rs});
      chk($sformatf("v%0d_vm", i), 32'(bus.ValidM), 32'h1);
    end

    // Stall for 3 cycles: EX/MEM keeps the last table entry.
    s = mk(ALU_ADD, 32'd1, 32'd1, 32'd0, 0, 2'd0, 2'd0, 32'd0, 32'h40, 0, 0, 20, 0, 1, 2'd1,
           32'd0, 32'd0, 0, 32'h0);
    drive(s, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk($sformatf("stall%0d_alum", i), bus.ALUResultM, 32'h47);
      chk($sformatf("stall%0d_rdm", i), 32'(bus.RDM), 32'd15);
      chk($sformatf("stall%0d_ctl", i), {29'h0, bus.RegWriteM, bus.MemWriteM, bus.ValidM}, 32'b101);
      chk($sformatf("stall%0d_pc4m", i), bus.PCPlus4M, 32'h28);
    end

    // Flush together with stall: bubble wins.
    s.rw = 1'b1;
    drive(s, 1'b1, 1'b1);
    @(posedge clk); #1;
    chk("flush_rwm", 32'(bus.RegWriteM), 32'h0);
    chk("flush_mwm", 32'(bus.MemWriteM), 32'h0);
    chk("flush_vm", 32'(bus.ValidM), 32'h0);

    // Wrap-around add, then asynchronous reset mid-cycle with a store pending.
    s = mk(ALU_ADD, 32'hFFFFFFFF, 32'd1, 32'd0, 0, 2'd0, 2'd0, 32'd0, 32'h200, 0, 0, 17, 0, 1, 2'd1,
           32'd0, 32'd1, 0, 32'h200);
    drive(s, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("wrap_alum", bus.ALUResultM, 32'h0);
    chk("wrap_mwm", 32'(bus.MemWriteM), 32'h1);
    chk("wrap_rdm", 32'(bus.RDM), 32'd17);
    chk("wrap_vm", 32'(bus.ValidM), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_mwm", 32'(bus.MemWriteM), 32'h0);
    chk("arst_vm", 32'(bus.ValidM), 32'h0);
    chk("arst_rdm", 32'(bus.RDM), 32'h0);
    chk("arst_pc4m", bus.PCPlus4M, 32'h0);
    #4 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_mwm", 32'(bus.MemWriteM), 32'h1);
    chk("post_vm", 32'(bus.ValidM), 32'h1);
    chk("post_rdm", 32'(bus.RDM), 32'd17);
    chk("post_pc4m", bus.PCPlus4M, 32'h204);
    chk("post_wdm", bus.WriteDataM, 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
